cache_arbiter: RTL and testbench

Shares the single cacheline-wide physical memory port between the instruction cache (read-only) and the data cache (read/write). It grants one requester at a time, latches that request, holds it stable on the memory port until the memory responds, and returns the response only to the granted cache. Requests alternate between the two caches when both are pending, so neither cache starves.

---
 rtl/cache_arb_pkg.sv | 25 ++
 rtl/cache_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg
// Shared types and default widths for the cache arbiter that puts the
// I-cache and D-cache onto one cacheline-wide physical memory port.
//   state_t     : arbiter FSM states
//   owner_t     : which cache holds (or last held) the memory port
//   DEF_LINE_W  : default cacheline width in bits
//   DEF_ADDR_W  : default byte address width
package cache_arb_pkg;

    localparam int DEF_LINE_W = 256;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter
// Grants the single physical memory port to either the I-cache (read only)
// or the D-cache (read / write-back), one transaction at a time. The granted
// request is latched and held on the memory port until mem_resp, then the
// response is pulsed back to the owner only. When both caches are waiting,
// the one not served last wins, so neither starves.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_read, i_addr               I-cache line read request (held until i_resp)
//   i_rdata, i_resp              line and one-cycle completion to the I-cache
//   d_read, d_write, d_addr,     D-cache read / write-back request
//   d_wdata                      (held until d_resp), write-back line
//   d_rdata, d_resp              line and one-cycle completion to the D-cache
//   mem_read, mem_write,         physical memory command, address and
//   mem_addr, mem_wdata          write data
//   mem_rdata, mem_resp          physical memory read data and completion
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    state_t state;
    state_t state_next;

    // The owner of the current grant doubles as the last-served bit: it only
    // changes on a grant, so outside a transaction it names whoever went last.
    owner_t owner;

    logic              cmd_read;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LINE_W-1:0] cmd_wdata;
    logic [LINE_W-1:0] rdata;

    logic i_pending;
    logic d_pending;
    logic grant_i;
    logic grant_d;
    logic serving;

    assign i_pending = i_read;
    assign d_pending = d_read | d_write;

    // D wins when it is alone, or on a tie when I went last (including the
    // reset case, where last-served reads as I).
    assign grant_d = d_pending && (!i_pending || owner == OWN_I);
    assign grant_i = i_pending && !grant_d;

    assign serving = (state == SERVE_I) || (state == SERVE_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                mem_read  = cmd_read;
                mem_write = cmd_write;
                if (mem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                i_resp     = (owner == OWN_I);
                d_resp     = (owner == OWN_D);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command bundle is captured only at grant time, so anything the caches
    // do to their request lines during service never reaches memory. The
    // shared rdata register only moves on a read completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_I;
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && (grant_i || grant_d)) begin
                owner     <= grant_d ? OWN_D : OWN_I;
                cmd_write <= grant_d && d_write;
                cmd_read  <= grant_i || (grant_d && !d_write);
                cmd_addr  <= grant_d ? d_addr : i_addr;
                cmd_wdata <= grant_d ? d_wdata : '0;
            end
            if (serving && mem_resp && cmd_read) begin
                rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Self-checking bench for cache_arbiter: a table of directed transactions
// from reset, a few hand-written multi-cycle sequences (input change during
// service, reset mid-transaction), then randomized transactions whose grant
// order and returned data come from a small reference model.
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int num_compared;
    int num_mismatched;

    // Line most recently returned by a memory read; what both rdata outputs
    // must show.
    logic [255:0] exp_rdata;

    // History of grants for the random phase: 1 = D, 0 = I.
    bit served[$];

    typedef struct {
        logic         ir;
        logic         dr;
        logic         dw;
        logic [31:0]  ia;
        logic [31:0]  da;
        logic [255:0] wd;
        logic [255:0] rd;
        int           lat;
        logic         exp_d;
        logic         exp_wr;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs[10];

    localparam logic [255:0] LINE_A5   = {32{8'hA5}};
    localparam logic [255:0] LINE_DEAD = {16{16'hDEAD}};
    localparam logic [255:0] LINE_GARB = {8{32'hBAD0_BAD0}};

    cache_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkBit({tag, " mem_read"}, mem_read, 1'b0);
        checkBit({tag, " mem_write"}, mem_write, 1'b0);
        checkBit({tag, " i_resp"}, i_resp, 1'b0);
        checkBit({tag, " d_resp"}, d_resp, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkQuiet(tag);
        checkOutput({tag, " mem_addr"}, 256'(mem_addr), 256'h0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 256'h0);
        checkOutput({tag, " i_rdata"}, i_rdata, 256'h0);
        checkOutput({tag, " d_rdata"}, d_rdata, 256'h0);
    endtask

    task automatic doReset();
        rst       = 1'b1;
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
        step();
        step();
        checkAllZero("reset");
        rst       = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic checkCommand(input string tag, input logic exp_wr,
                                input logic [31:0] exp_addr, input logic [255:0] wd);
        checkBit({tag, " mem_read"}, mem_read, !exp_wr);
        checkBit({tag, " mem_write"}, mem_write, exp_wr);
        checkOutput({tag, " mem_addr"}, 256'(mem_addr), 256'(exp_addr));
        if (exp_wr) begin
            checkOutput({tag, " mem_wdata"}, mem_wdata, wd);
        end
        checkBit({tag, " i_resp"}, i_resp, 1'b0);
        checkBit({tag, " d_resp"}, d_resp, 1'b0);
    endtask

    // One full transaction, entered in an IDLE cycle. The request is held
    // until the resp cycle and dropped there; memory answers after 'lat'
    // wait cycles (lat = 0 means mem_resp in the cycle the command rises).
    // With 'scramble' set, the request lines are disturbed during service.
    task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [255:0] wd, input logic [255:0] rd,
                                 input int lat, input logic scramble,
                                 input logic exp_d, input logic exp_wr,
                                 input logic [31:0] exp_addr);
        i_read  = ir;
        d_read  = dr;
        d_write = dw;
        i_addr  = ia;
        d_addr  = da;
        d_wdata = wd;
        step();
        checkCommand("grant", exp_wr, exp_addr, wd);
        for (int c = 0; c < lat; c++) begin
            if (scramble) begin
                d_addr  = d_addr ^ 32'h0000_0300;
                i_addr  = i_addr ^ 32'h0000_0300;
                d_wdata = ~d_wdata;
                i_read  = ~i_read;
                d_write = ~d_write;
            end
            step();
            checkCommand("hold", exp_wr, exp_addr, wd);
        end
        mem_resp  = 1'b1;
        mem_rdata = rd;
        step();
        mem_resp  = 1'b0;
        mem_rdata = LINE_GARB;
        if (!exp_wr) begin
            exp_rdata = rd;
        end
        checkBit("done i_resp", i_resp, !exp_d);
        checkBit("done d_resp", d_resp, exp_d);
        checkBit("done mem_read", mem_read, 1'b0);
        checkBit("done mem_write", mem_write, 1'b0);
        checkOutput("done i_rdata", i_rdata, exp_rdata);
        checkOutput("done d_rdata", d_rdata, exp_rdata);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        step();
        checkQuiet("after");
        checkOutput("after d_rdata", d_rdata, exp_rdata);
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] tmp;
        for (int w = 0; w < 8; w++) begin
            tmp[w*32 +: 32] = $urandom;
        end
        return tmp;
    endfunction

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        rst            = 1'b1;

        //               ir    dr    dw    ia            da            wd                  rd                  lat exp_d exp_wr addr
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0400, 256'h0,            {8{32'h1111_0001}}, 1, 1'b1, 1'b0, 32'h0000_0400};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0340, 32'h0000_0440, 256'h0,            {8{32'h2222_0002}}, 2, 1'b0, 1'b0, 32'h0000_0340};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0380, 32'h0000_0480, 256'h0,            {8{32'h3333_0003}}, 0, 1'b1, 1'b0, 32'h0000_0480};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_03C0, 32'h0000_04C0, 256'h0,            {8{32'h4444_0004}}, 1, 1'b0, 1'b0, 32'h0000_03C0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 256'h0,            LINE_A5,            3, 1'b0, 1'b0, 32'h0000_0040};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_1000, LINE_DEAD,         LINE_GARB,          2, 1'b1, 1'b1, 32'h0000_1000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0600, {8{32'h5555_0005}}, {8{32'h6666_0006}}, 1, 1'b0, 1'b0, 32'h0000_0500};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_2000, {8{32'h7777_0007}}, LINE_GARB,          0, 1'b1, 1'b1, 32'h0000_2000};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0000_0000, 256'h0,            {8{32'h8888_0008}}, 0, 1'b0, 1'b0, 32'h0000_0080};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0A00, 256'h0,            {8{32'h9999_0009}}, 2, 1'b1, 1'b0, 32'h0000_0A00};

        doReset();

        $display("[TB] directed table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].ir, vecs[v].dr, vecs[v].dw, vecs[v].ia, vecs[v].da,
                          vecs[v].wd, vecs[v].rd, vecs[v].lat, 1'b0,
                          vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_addr);
        end

        $display("[TB] address change during service");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100, 256'h0, {8{32'hC0DE_0100}},
                      3, 1'b1, 1'b1, 1'b0, 32'h0000_0100);

        $display("[TB] reset in the middle of an I read");
        i_read = 1'b1;
        i_addr = 32'h0000_80C0;
        step();
        checkBit("rstseq mem_read", mem_read, 1'b1);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        i_read    = 1'b0;
        exp_rdata = '0;
        checkAllZero("rstseq");
        mem_resp  = 1'b1;
        mem_rdata = LINE_GARB;
        step();
        mem_resp = 1'b0;
        checkQuiet("rstseq idle");
        checkOutput("rstseq rdata", i_rdata, 256'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0700, 256'h0, {8{32'hD00D_0700}},
                      1, 1'b0, 1'b1, 1'b0, 32'h0000_0700);

        $display("[TB] randomized transactions");
        doReset();
        served.delete();
        for (int n = 0; n < 150; n++) begin
            logic ir, dr, dw, win_d, wr;
            logic [31:0] ia, da;
            logic [255:0] wd, rd;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ia = $urandom;
            da = $urandom;
            wd = randLine();
            rd = randLine();
            if (!ir && !dr && !dw) begin
                // Nothing pending: a stray mem_resp must not start anything.
                mem_resp = 1'($urandom_range(0, 1));
                step();
                mem_resp = 1'b0;
                checkQuiet("rand idle");
                step();
                checkQuiet("rand idle2");
            end else begin
                // Model: a lone requester wins; on a tie the cache that was
                // not served last wins, and no history counts as I last.
                if (ir && (dr || dw)) begin
                    win_d = (served.size() == 0) ? 1'b1 : !served[$];
                end else begin
                    win_d = dr || dw;
                end
                wr = win_d && dw;
                served.push_back(win_d);
                applyStimulus(ir, dr, dw, ia, da, wd, rd,
                              $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                              win_d, wr, win_d ? da : ia);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
